// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift-register sequencer: register mode codes and FSM states.
package shift_seq_pkg;

  // {S1,S0} codes understood by the universal shift register
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_FIN   = 2'b11
  } state_t;

endpackage

// File: rtl/shift_seq_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero so it never wraps.
module shift_seq_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (dec && (value_reg != '0)) begin
      value_reg <= value_reg - 1'b1;
    end
  end

  assign value = value_reg;
  assign zero  = (value_reg == '0);

endmodule

// File: rtl/shift_reg_sequencer.sv
// Job sequencer for a universal shift register: load, shift N places, capture.
// Optional rotate mode (serial inputs fed back from q) enabled by SHIFT_SEQ_ROTATE_EN.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic             serial_in,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic [WIDTH-1:0] q,
  output logic             s1,
  output logic             s0,
  output logic             sr,
  output logic             sl,
  output logic [WIDTH-1:0] par,
  output logic             cr_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  state_t           state_reg;
  logic             dir_l_reg;
  logic [WIDTH-1:0] par_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             done_reg;
  logic [CNT_W-1:0] remaining;
  logic             remaining_zero;
  logic [1:0]       mode;

  wire accept = (state_reg == ST_IDLE) && start;

  shift_seq_down_counter #(.CNT_W(CNT_W)) u_remaining (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (count),
    .dec        (state_reg == ST_SHIFT),
    .value      (remaining),
    .zero       (remaining_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dir_l_reg <= 1'b0;
      par_reg   <= '0;
      dout_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            par_reg   <= din;
            dir_l_reg <= dir;
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD:  state_reg <= remaining_zero ? ST_FIN : ST_SHIFT;
        // the last shift edge is the one where a single step remains
        ST_SHIFT: if (remaining == CNT_W'(1)) state_reg <= ST_FIN;
        ST_FIN: begin
          dout_reg  <= q;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mode = MODE_HOLD;
    case (state_reg)
      ST_LOAD:  mode = MODE_LOAD;
      ST_SHIFT: mode = dir_l_reg ? MODE_SHL : MODE_SHR;
      default:  mode = MODE_HOLD;
    endcase
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rotate_l_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rotate_l_reg <= 1'b0;
    end else if (accept) begin
      rotate_l_reg <= rotate;
    end
  end

  // rotating recirculates the bit leaving the far end of the register
  assign sr = rotate_l_reg ? q[WIDTH-1] : serial_in;
  assign sl = rotate_l_reg ? q[0]       : serial_in;
`else
  assign sr = serial_in;
  assign sl = serial_in;
`endif

  assign {s1, s0} = mode;
  assign par      = par_reg;
  assign cr_n     = ~rst;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign dout     = dout_reg;

endmodule
